// File: rtl/kuz_key_expander_pkg.sv
// Kuznechik shared definitions: pi S-box, linear-layer coefficients, GF(2^8) arithmetic,
// R/S transforms and the round-constant generator used to build the C1..C32 ROM.
package kuz_key_expander_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR_A = 3'd1,
    ST_WR_B = 3'd2,
    ST_XS   = 3'd3,
    ST_LR   = 3'd4
  } state_t;

  localparam logic [7:0] PI [256] = '{
    8'hFC, 8'hEE, 8'hDD, 8'h11, 8'hCF, 8'h6E, 8'h31, 8'h16, 8'hFB, 8'hC4, 8'hFA, 8'hDA, 8'h23, 8'hC5, 8'h04, 8'h4D,
    8'hE9, 8'h77, 8'hF0, 8'hDB, 8'h93, 8'h2E, 8'h99, 8'hBA, 8'h17, 8'h36, 8'hF1, 8'hBB, 8'h14, 8'hCD, 8'h5F, 8'hC1,
    8'hF9, 8'h18, 8'h65, 8'h5A, 8'hE2, 8'h5C, 8'hEF, 8'h21, 8'h81, 8'h1C, 8'h3C, 8'h42, 8'h8B, 8'h01, 8'h8E, 8'h4F,
    8'h05, 8'h84, 8'h02, 8'hAE, 8'hE3, 8'h6A, 8'h8F, 8'hA0, 8'h06, 8'h0B, 8'hED, 8'h98, 8'h7F, 8'hD4, 8'hD3, 8'h1F,
    8'hEB, 8'h34, 8'h2C, 8'h51, 8'hEA, 8'hC8, 8'h48, 8'hAB, 8'hF2, 8'h2A, 8'h68, 8'hA2, 8'hFD, 8'h3A, 8'hCE, 8'hCC,
    8'hB5, 8'h70, 8'h0E, 8'h56, 8'h08, 8'h0C, 8'h76, 8'h12, 8'hBF, 8'h72, 8'h13, 8'h47, 8'h9C, 8'hB7, 8'h5D, 8'h87,
    8'h15, 8'hA1, 8'h96, 8'h29, 8'h10, 8'h7B, 8'h9A, 8'hC7, 8'hF3, 8'h91, 8'h78, 8'h6F, 8'h9D, 8'h9E, 8'hB2, 8'hB1,
    8'h32, 8'h75, 8'h19, 8'h3D, 8'hFF, 8'h35, 8'h8A, 8'h7E, 8'h6D, 8'h54, 8'hC6, 8'h80, 8'hC3, 8'hBD, 8'h0D, 8'h57,
    8'hDF, 8'hF5, 8'h24, 8'hA9, 8'h3E, 8'hA8, 8'h43, 8'hC9, 8'hD7, 8'h79, 8'hD6, 8'hF6, 8'h7C, 8'h22, 8'hB9, 8'h03,
    8'hE0, 8'h0F, 8'hEC, 8'hDE, 8'h7A, 8'h94, 8'hB0, 8'hBC, 8'hDC, 8'hE8, 8'h28, 8'h50, 8'h4E, 8'h33, 8'h0A, 8'h4A,
    8'hA7, 8'h97, 8'h60, 8'h73, 8'h1E, 8'h00, 8'h62, 8'h44, 8'h1A, 8'hB8, 8'h38, 8'h82, 8'h64, 8'h9F, 8'h26, 8'h41,
    8'hAD, 8'h45, 8'h46, 8'h92, 8'h27, 8'h5E, 8'h55, 8'h2F, 8'h8C, 8'hA3, 8'hA5, 8'h7D, 8'h69, 8'hD5, 8'h95, 8'h3B,
    8'h07, 8'h58, 8'hB3, 8'h40, 8'h86, 8'hAC, 8'h1D, 8'hF7, 8'h30, 8'h37, 8'h6B, 8'hE4, 8'h88, 8'hD9, 8'hE7, 8'h89,
    8'hE1, 8'h1B, 8'h83, 8'h49, 8'h4C, 8'h3F, 8'hF8, 8'hFE, 8'h8D, 8'h53, 8'hAA, 8'h90, 8'hCA, 8'hD8, 8'h85, 8'h61,
    8'h20, 8'h71, 8'h67, 8'hA4, 8'h2D, 8'h2B, 8'h09, 8'h5B, 8'hCB, 8'h9B, 8'h25, 8'hD0, 8'hBE, 8'hE5, 8'h6C, 8'h52,
    8'h59, 8'hA6, 8'h74, 8'hD2, 8'hE6, 8'hF4, 8'hB4, 8'hC0, 8'hD1, 8'h66, 8'hAF, 8'hC2, 8'h39, 8'h4B, 8'h63, 8'hB6
  };

  // Indexed by byte position: entry j multiplies a_j (a15 = bits [127:120]).
  localparam logic [7:0] L_COEF [16] = '{
    8'd1, 8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1,
    8'd251, 8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148
  };

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'd0;
    x = a;
    y = b;
    for (int k = 0; k < 8; k++) begin
      p = y[0] ? (p ^ x) : p;
      x = x[7] ? ((x << 1) ^ 8'hC3) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] r_func(input logic [127:0] a);
    logic [7:0] l;
    l = 8'd0;
    for (int j = 0; j < 16; j++) begin
      l = l ^ gf_mul(a[8*j +: 8], L_COEF[j]);
    end
    return {l, a[127:8]};
  endfunction

  function automatic logic [127:0] s_layer(input logic [127:0] a);
    logic [127:0] res;
    res = 128'd0;
    for (int j = 0; j < 16; j++) begin
      res[8*j +: 8] = PI[a[8*j +: 8]];
    end
    return res;
  endfunction

  // Ci = L(Vec128(i)); evaluated at elaboration to fill the constant ROM.
  function automatic logic [127:0] kuz_const(input int n);
    logic [127:0] v;
    v = {120'd0, 8'(n)};
    for (int k = 0; k < 16; k++) begin
      v = r_func(v);
    end
    return v;
  endfunction

endpackage

// File: rtl/kuz_key_expander_r_step.sv
// Combinational Kuznechik R step: R(a) = l(a) || a15..a1. Shared with the cipher's L layer.
module kuz_key_expander_r_step (
  input  logic [127:0] din,
  output logic [127:0] dout
);
  import kuz_key_expander_pkg::*;

  assign dout = r_func(din);

endmodule

// File: rtl/kuz_key_expander.sv
// Kuznechik key schedule: expands a 256-bit master key into K1..K10 and streams them
// into round-key storage, one S cycle plus 16 R cycles per Feistel round.
module kuz_key_expander #(
  parameter logic [3:0] BASE_ADDR = 4'd0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] master_key,
  output logic         busy,
  output logic         done,
  output logic [127:0] key_data,
  output logic [3:0]   key_addr,
  output logic         key_we
);
  import kuz_key_expander_pkg::*;

  state_t       state, state_n;
  logic [127:0] a1, a0, t, a1_n, a0_n, t_n, key_data_n, f;
  logic [3:0]   r, r_n, key_addr_n;
  logic [5:0]   i, i_n;
  logic [2:0]   pair, pair_n;
  logic         key_we_n, done_n, busy_n;
  logic [127:0] c_rom [32];

  // ROM slot k holds Ck; slot 0 holds C32 so i[4:0] indexes it directly for i = 1..32.
  for (genvar g = 0; g < 32; g++) begin : g_crom
    localparam logic [127:0] CV = kuz_const((g == 0) ? 32 : g);
    assign c_rom[g] = CV;
  end

  kuz_key_expander_r_step u_r_step (
    .din  (t),
    .dout (f)
  );

  // Next-state, datapath and registered-output values.
  always_comb begin
    state_n    = state;
    a1_n       = a1;
    a0_n       = a0;
    t_n        = t;
    r_n        = r;
    i_n        = i;
    pair_n     = pair;
    key_we_n   = 1'b0;
    done_n     = 1'b0;
    key_data_n = key_data;
    key_addr_n = key_addr;
    case (state)
      ST_IDLE: begin
        if (start) begin
          a1_n       = master_key[255:128];
          a0_n       = master_key[127:0];
          i_n        = 6'd1;
          pair_n     = 3'd0;
          state_n    = ST_WR_A;
          key_we_n   = 1'b1;
          key_data_n = master_key[255:128];
          key_addr_n = BASE_ADDR;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_WR_A: begin
        state_n    = ST_WR_B;
        key_we_n   = 1'b1;
        key_data_n = a0;
        key_addr_n = key_addr + 4'd1;
        done_n     = (pair == 3'd4);
      end
      ST_WR_B: begin
        if (pair == 3'd4) begin
          state_n = ST_IDLE;
        end else begin
          pair_n  = pair + 3'd1;
          state_n = ST_XS;
        end
      end
      ST_XS: begin
        t_n     = s_layer(a1 ^ c_rom[i[4:0]]);
        r_n     = 4'd0;
        state_n = ST_LR;
      end
      ST_LR: begin
        t_n = f;
        r_n = r + 4'd1;
        if (r == 4'd15) begin
          a1_n = f ^ a0;
          a0_n = a1;
          i_n  = i + 6'd1;
          // Every eighth round completes a key pair.
          if (i[2:0] == 3'd0) begin
            state_n    = ST_WR_A;
            key_we_n   = 1'b1;
            key_data_n = f ^ a0;
            key_addr_n = BASE_ADDR + {pair, 1'b0};
          end else begin
            state_n = ST_XS;
          end
        end else begin
          state_n = ST_LR;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
    busy_n = (state_n != ST_IDLE);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      a1       <= 128'd0;
      a0       <= 128'd0;
      t        <= 128'd0;
      r        <= 4'd0;
      i        <= 6'd0;
      pair     <= 3'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      key_we   <= 1'b0;
      key_addr <= BASE_ADDR;
      key_data <= 128'd0;
    end else begin
      state    <= state_n;
      a1       <= a1_n;
      a0       <= a0_n;
      t        <= t_n;
      r        <= r_n;
      i        <= i_n;
      pair     <= pair_n;
      busy     <= busy_n;
      done     <= done_n;
      key_we   <= key_we_n;
      key_addr <= key_addr_n;
      key_data <= key_data_n;
    end
  end

endmodule

// File: tb/tb_kuz_key_expander.sv
// Directed bench for kuz_key_expander: standard-vector key table, latency, restart/reset
// corner cases, with BASE_ADDR=0 and BASE_ADDR=6 instances driven in parallel.
module tb_kuz_key_expander;
  import kuz_key_expander_pkg::*;

  typedef struct {
    logic [3:0]   off;
    logic [127:0] exp;
  } vec_t;

  localparam logic [255:0] STD_KEY =
    256'h8899aabbccddeeff0011223344556677_fedcba98765432100123456789abcdef;
  localparam logic [3:0] BASES [2] = '{4'd0, 4'd6};

  logic         clk = 1'b0;
  logic         rst, start;
  logic [255:0] master_key;
  logic         busy0, done0, we0, busy1, done1, we1;
  logic [127:0] data0, data1;
  logic [3:0]   addr0, addr1;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int base = 0;
  logic [127:0] mem [2][16];
  int wcnt [2];
  int first_rel [2];
  int done_cnt [2];
  int done_rel [2];
  int busy_first [2];
  int busy_last [2];
  bit asc_bad [2];
  vec_t tab [5];

  always #5 clk = ~clk;

  kuz_key_expander #(.BASE_ADDR(4'd0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .master_key(master_key),
    .busy(busy0), .done(done0), .key_data(data0), .key_addr(addr0), .key_we(we0)
  );

  kuz_key_expander #(.BASE_ADDR(4'd6)) dut6 (
    .clk(clk), .rst(rst), .start(start), .master_key(master_key),
    .busy(busy1), .done(done1), .key_data(data1), .key_addr(addr1), .key_we(we1)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic log_one(input int k, input logic we, input logic [3:0] a, input logic [127:0] d,
                         input logic dn, input logic bz, input int rel);
    if (we) begin
      mem[k][a] = d;
      if (a != BASES[k] + 4'(wcnt[k])) asc_bad[k] = 1'b1;
      if (wcnt[k] == 0) first_rel[k] = rel;
      wcnt[k]++;
    end
    if (dn) begin
      done_cnt[k]++;
      done_rel[k] = rel;
    end
    if (bz) begin
      if (busy_first[k] < 0) busy_first[k] = rel;
      busy_last[k] = rel;
    end
  endtask

  // Storage model and run statistics, sampled mid-cycle.
  always @(negedge clk) begin
    log_one(0, we0, addr0, data0, done0, busy0, cyc - base);
    log_one(1, we1, addr1, data1, done1, busy1, cyc - base);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic clear_log();
    for (int k = 0; k < 2; k++) begin
      wcnt[k] = 0;
      first_rel[k] = -1;
      done_cnt[k] = 0;
      done_rel[k] = -1;
      busy_first[k] = -1;
      busy_last[k] = -1;
      asc_bad[k] = 1'b0;
      for (int m = 0; m < 16; m++) mem[k][m] = 128'd0;
    end
  endtask

  task automatic start_run(input logic [255:0] key);
    @(negedge clk);
    clear_log();
    base = cyc;
    master_key = key;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_run(input string tag);
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 5; j++) begin
        check($sformatf("%s_d%0d_key_off%0d", tag, k, tab[j].off),
              mem[k][BASES[k] + tab[j].off], tab[j].exp);
      end
      check($sformatf("%s_d%0d_we_count", tag, k), 128'(wcnt[k]), 128'd10);
      check($sformatf("%s_d%0d_addr_order", tag, k), 128'(asc_bad[k]), 128'd0);
      check($sformatf("%s_d%0d_first_write", tag, k), 128'(first_rel[k]), 128'd1);
      check($sformatf("%s_d%0d_done_cycle", tag, k), 128'(done_rel[k]), 128'd554);
      check($sformatf("%s_d%0d_done_width", tag, k), 128'(done_cnt[k]), 128'd1);
      check($sformatf("%s_d%0d_busy_first", tag, k), 128'(busy_first[k]), 128'd1);
      check($sformatf("%s_d%0d_busy_last", tag, k), 128'(busy_last[k]), 128'd554);
    end
  endtask

  task automatic wait_done(input bit poke_mid, input bit poke_done, output bit got);
    got = 1'b0;
    for (int n = 0; n < 700; n++) begin
      @(negedge clk);
      if (poke_mid && (cyc - base == 100)) begin
        start = 1'b1;
        master_key = ~STD_KEY;
      end else if (done0) begin
        start = poke_done;
        got = 1'b1;
        break;
      end else begin
        start = 1'b0;
      end
    end
    if (!got) check("done_timeout", 128'd0, 128'd1);
  endtask

  initial begin
    bit got;
    tab[0] = '{off: 4'd0, exp: 128'h8899aabbccddeeff0011223344556677};
    tab[1] = '{off: 4'd1, exp: 128'hfedcba98765432100123456789abcdef};
    tab[2] = '{off: 4'd2, exp: 128'hdb31485315694343228d6aef8cc78c44};
    tab[3] = '{off: 4'd3, exp: 128'h3d4553d8e9cfec6815ebadc40a9ffd04};
    tab[4] = '{off: 4'd9, exp: 128'h72e9dd7416bcf45b755dbaa88e4a4043};

    rst = 1'b1;
    start = 1'b0;
    master_key = 256'd0;
    clear_log();
    repeat (3) @(negedge clk);
    check("rst_busy", 128'({busy0, busy1}), 128'd0);
    check("rst_done", 128'({done0, done1}), 128'd0);
    check("rst_we", 128'({we0, we1}), 128'd0);
    check("rst_addr0", 128'(addr0), 128'd0);
    check("rst_addr6", 128'(addr1), 128'd6);
    check("rst_data", data0 | data1, 128'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    check("c1_const", kuz_const(1), 128'h6ea276726c487ab85d27bd10dd849401);

    // Run 1: extra start plus key change at cycle 100, and start in the done cycle.
    start_run(STD_KEY);
    wait_done(1'b1, 1'b1, got);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_done", 128'({busy0, busy1}), 128'd0);
    @(negedge clk);
    check("start_in_done_ignored", 128'({busy0, busy1, we0, we1}), 128'd0);
    repeat (3) @(negedge clk);
    check_run("run1");

    // Run 2: reset asserted at cycle 300.
    start_run(STD_KEY);
    while (cyc - base < 300) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 128'({busy0, busy1}), 128'd0);
    check("midrst_we", 128'({we0, we1}), 128'd0);
    repeat (60) @(negedge clk);
    check("midrst_writes_d0", 128'(wcnt[0]), 128'd6);
    check("midrst_writes_d6", 128'(wcnt[1]), 128'd6);

    // Run 3: clean run after the reset.
    start_run(STD_KEY);
    wait_done(1'b0, 1'b0, got);
    repeat (4) @(negedge clk);
    check_run("run3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
